// File: rtl/huff_ctrl_gen2_if.sv
// Handshake bundle between the Huffman decoder controller, the maxcode/LUT
// match logic and the coefficient shift register.
interface huff_ctrl_gen2_if #(
    parameter int POS_W  = 4,
    parameter int SIZE_W = 4,
    parameter int RUN_W  = 2
);
    logic              init_req;
    logic              init_dc_ac;
    logic              init_sr;
    logic              match;
    logic              eob;
    logic [SIZE_W-1:0] coeff_size;
    logic [RUN_W-1:0]  run_length;
    logic              dc_ac;
    logic              reset_sr;
    logic              shift_en;
    logic              valid;
    logic [POS_W-1:0]  position;
    logic              new_block;
    logic              block_done;
    logic              pos_err;

    modport master (
        output init_req, init_dc_ac, init_sr, match, eob, coeff_size, run_length,
        input  dc_ac, reset_sr, shift_en, valid, position, new_block, block_done, pos_err
    );

    modport slave (
        input  init_req, init_dc_ac, init_sr, match, eob, coeff_size, run_length,
        output dc_ac, reset_sr, shift_en, valid, position, new_block, block_done, pos_err
    );
endinterface

// File: rtl/huff_ctrl_gen2.sv
// Huffman decoder controller: DC/AC decode sequencing, coefficient shift-in and
// block position tracking. Define HUFF_POS_CHECK_EN to drop AC codes that overrun the block.
module huff_ctrl_gen2 #(
    parameter int POS_W  = 4,
    parameter int SIZE_W = 4,
    parameter int RUN_W  = 2
) (
    input  logic            phi1,
    input  logic            reset_b,
    huff_ctrl_gen2_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_DC_DEC  = 3'd2,
        S_DC_COEF = 3'd3,
        S_AC_DEC  = 3'd4,
        S_AC_COEF = 3'd5
    } state_t;

    localparam logic [POS_W-1:0]  PMAX    = '1;
    localparam logic [SIZE_W-1:0] CNT_ONE = SIZE_W'(1);

    state_t            state_q;
    logic [POS_W-1:0]  pos_q;
    logic [SIZE_W-1:0] cnt_q;
    logic              entry_q;
    logic              valid_q;
    logic              shift_q;
    logic              new_block_q;
    logic              done_q;
    logic              reset_sr;
    logic              match_ok;
    logic              dc_ac;
    logic [POS_W-1:0]  ac_pos;

    // entry_q marks the first cycle of a decode state; codes seen then are stale
    assign reset_sr = entry_q | bus.init_sr;
    assign match_ok = bus.match & ~reset_sr;

`ifdef HUFF_POS_CHECK_EN
    logic [POS_W:0] ac_sum;
    logic           ac_ovf;
    logic           pos_err_q;

    assign ac_sum = {1'b0, pos_q} + (POS_W+1)'(bus.run_length) + (POS_W+1)'(1);
    assign ac_ovf = ac_sum > {1'b0, PMAX};
    assign ac_pos = ac_sum[POS_W-1:0];
    assign bus.pos_err = pos_err_q;
`else
    assign ac_pos = pos_q + POS_W'(bus.run_length) + POS_W'(1);
    assign bus.pos_err = 1'b0;
`endif

    always_ff @(posedge phi1) begin
        if (!reset_b) begin
            state_q     <= S_IDLE;
            pos_q       <= PMAX;
            cnt_q       <= '0;
            entry_q     <= 1'b0;
            valid_q     <= 1'b0;
            shift_q     <= 1'b0;
            new_block_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef HUFF_POS_CHECK_EN
            pos_err_q   <= 1'b0;
`endif
        end else begin
            entry_q     <= 1'b0;
            valid_q     <= 1'b0;
            shift_q     <= 1'b0;
            new_block_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef HUFF_POS_CHECK_EN
            pos_err_q   <= 1'b0;
`endif
            if (bus.init_req) begin
                state_q <= S_INIT;
                cnt_q   <= '0;
                pos_q   <= PMAX;
            end else begin
                case (state_q)
                    S_IDLE: state_q <= S_IDLE;
                    S_INIT: begin
                        state_q     <= S_DC_DEC;
                        entry_q     <= 1'b1;
                        new_block_q <= 1'b1;
                        pos_q       <= PMAX;
                    end
                    S_DC_DEC: begin
                        if (match_ok) begin
                            pos_q <= '0;
                            if (bus.coeff_size == '0) begin
                                state_q <= S_AC_DEC;
                                valid_q <= 1'b1;
                                entry_q <= 1'b1;
                            end else begin
                                state_q <= S_DC_COEF;
                                cnt_q   <= bus.coeff_size;
                                shift_q <= 1'b1;
                            end
                        end
                    end
                    S_DC_COEF, S_AC_COEF: begin
                        // the valid cycle is also the re-entry cycle of AC_DEC
                        if (cnt_q <= CNT_ONE) begin
                            cnt_q   <= '0;
                            state_q <= S_AC_DEC;
                            valid_q <= 1'b1;
                            entry_q <= 1'b1;
                            done_q  <= (state_q == S_AC_COEF) && (pos_q == PMAX);
                        end else begin
                            cnt_q   <= cnt_q - CNT_ONE;
                            shift_q <= 1'b1;
                        end
                    end
                    S_AC_DEC: begin
                        if (done_q) begin
                            state_q     <= S_DC_DEC;
                            entry_q     <= 1'b1;
                            new_block_q <= 1'b1;
                            pos_q       <= PMAX;
                        end else if (match_ok) begin
                            if (bus.eob) begin
                                state_q     <= S_DC_DEC;
                                entry_q     <= 1'b1;
                                new_block_q <= 1'b1;
                                done_q      <= 1'b1;
                                pos_q       <= PMAX;
                            end
`ifdef HUFF_POS_CHECK_EN
                            else if (ac_ovf) begin
                                state_q     <= S_DC_DEC;
                                entry_q     <= 1'b1;
                                new_block_q <= 1'b1;
                                done_q      <= 1'b1;
                                pos_err_q   <= 1'b1;
                                pos_q       <= PMAX;
                            end
`endif
                            else begin
                                pos_q <= ac_pos;
                                if (bus.coeff_size == '0) begin
                                    valid_q <= 1'b1;
                                    entry_q <= 1'b1;
                                    done_q  <= (ac_pos == PMAX);
                                end else begin
                                    state_q <= S_AC_COEF;
                                    cnt_q   <= bus.coeff_size;
                                    shift_q <= 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        pos_q   <= PMAX;
                    end
                endcase
            end
        end
    end

    always_comb begin
        dc_ac = bus.init_dc_ac;
        case (state_q)
            S_DC_DEC, S_DC_COEF: dc_ac = 1'b1;
            S_AC_DEC, S_AC_COEF: dc_ac = 1'b0;
            default:             dc_ac = bus.init_dc_ac;
        endcase
    end

    assign bus.dc_ac      = dc_ac;
    assign bus.reset_sr   = reset_sr;
    assign bus.shift_en   = shift_q;
    assign bus.valid      = valid_q;
    assign bus.position   = pos_q;
    assign bus.new_block  = new_block_q;
    assign bus.block_done = done_q;
endmodule

// File: doc/huff_ctrl_gen2.md
Name: huff_ctrl_gen2

Overview:
- Next-generation Huffman decoder controller, single-clock.
- Sequences DC/AC code decode, coefficient bit shift-in and position tracking for an N-position block.
- Sits between the maxcode match logic / LUTs and the coefficient shift register.
- Over the previous controller it adds:
  - parametrised block size, coefficient size and run-length widths;
  - explicit end-of-block (EOB) handling;
  - a block_done strobe;
  - optional position-overflow checking.

Parameters:
POS_W, 4, position width; block has 2**POS_W positions, last position PMAX = all ones
SIZE_W, 4, coefficient size width; sizes 0..2**SIZE_W-1 bits
RUN_W, 2, run-length width; zeros preceding current AC coefficient

Ports:
phi1  input  1  clock; all state updates on rising edge
reset_b  input  1  synchronous active-low reset
init_req  input  1  LUT initialisation in progress (holds controller in INIT)
init_dc_ac  input  1  table select driven to dc_ac while in IDLE/INIT
init_sr  input  1  external shift-register reset request, ORed into reset_sr
match  input  1  Huffman code found this cycle
eob  input  1  qualifies match in AC_DEC as end-of-block code
coeff_size  input  SIZE_W  bits of coefficient to shift in, valid with match
run_length  input  RUN_W  zero run, valid with match in AC_DEC
dc_ac  output  1  1 = DC table, 0 = AC table
reset_sr  output  1  reset shift registers
shift_en  output  1  shift one coefficient bit this cycle
valid  output  1  coefficient complete; position valid
position  output  POS_W  position of current coefficient
new_block  output  1  first cycle of a new block
block_done  output  1  block finished (PMAX reached or EOB)
pos_err  output  1  position overflow (see Optional Feature)

Behaviour:
- States: IDLE, INIT, DC_DEC, DC_COEF, AC_DEC, AC_COEF; registered; no other reachable encoding (illegal -> IDLE).
- Reset (reset_b=0 at edge):
  - state=IDLE, position=PMAX, counter=0.
  - Outputs: valid=0, shift_en=0, reset_sr=init_sr, new_block=0, block_done=0, pos_err=0, dc_ac=init_dc_ac.
- IDLE -> INIT when init_req=1.
- INIT -> DC_DEC when init_req=0.
- init_req=1 in any non-IDLE state -> INIT next cycle:
  - counter cleared, position=PMAX;
  - any pending valid suppressed.
- Decode entry: on every entry to DC_DEC or AC_DEC, reset_sr=1 for exactly that first cycle.
  - match is ignored in a cycle where reset_sr=1.
- Entry to DC_DEC also sets position=PMAX and new_block=1 for that one cycle.
- DC_DEC, match=1, size S:
  - position := PMAX+1 (wraps to 0);
  - S=0: valid=1 next cycle, state -> AC_DEC;
  - S>0: counter=S, state -> DC_COEF.
- DC_COEF / AC_COEF:
  - shift_en=1 every cycle; counter decrements.
  - Cycle with counter==1 is the last shift; the next cycle has valid=1 (single cycle) and the new state.
  - Latency: match at cycle t, S>0 -> shift_en high t+1..t+S, valid at t+S+1; S=0 -> valid at t+1.
- AC_DEC, match=1, eob=0:
  - position := position + run_length + 1, computed in POS_W+1 bits;
  - S=0 -> AC_DEC (valid next cycle); S>0 -> AC_COEF.
- AC_DEC, match=1, eob=1:
  - no valid;
  - block_done=1 next cycle;
  - state -> DC_DEC.
- Completion of an AC coefficient (the valid cycle):
  - position==PMAX -> block_done=1 same cycle as valid, next state DC_DEC;
  - otherwise -> AC_DEC.
- dc_ac:
  - 1 in DC_DEC/DC_COEF;
  - 0 in AC_DEC/AC_COEF;
  - init_dc_ac in IDLE/INIT.
- position holds between coefficients and is stable throughout the valid cycle.
- valid, new_block and block_done never high for more than one consecutive cycle per event.

Optional Feature:
- Macro: HUFF_POS_CHECK_EN.
- Defined:
  - If position+run_length+1 > PMAX on an AC match, the coefficient is dropped: no shift_en, no valid.
  - pos_err=1 for one cycle and block_done=1 the same cycle; state -> DC_DEC.
- Undefined:
  - position wraps modulo 2**POS_W and decoding continues normally.
  - pos_err is tied to 0.

Test Plan:
- Reset, then init_req high 3 cycles then low -> IDLE, INIT, DC_DEC. First DC_DEC cycle has reset_sr=1, new_block=1, position=15, dc_ac=1.
- DC match, size=3 -> shift_en high 3 cycles; valid on 4th cycle with position=0; state AC_DEC with reset_sr=1, dc_ac=0.
- AC match run=2, size=0 after position 0 -> valid next cycle, position=3, no shift_en.
- AC coefficients walking to position 15 -> on final valid, block_done=1 with position=15. Next cycle: DC_DEC, new_block=1, position=15.
- AC match with eob=1 at position 5 -> block_done=1, no valid, DC_DEC; match asserted during the reset_sr cycle is ignored.
- HUFF_POS_CHECK_EN, position=14, run=3 -> pos_err=1, block_done=1, no valid. Without the macro: valid with position=2 (wrapped).
- init_req asserted mid-AC_COEF with counter=2 -> INIT next cycle, no valid, shift_en=0.
